acc_data_mover: RTL and testbench

ACC_DATA_MOVER -- requirements
Module: acc_data_mover

---
 rtl/acc_mover_pkg.sv | 18 +
 rtl/mover_fifo.sv | 77 +++++++
 rtl/acc_data_mover.sv | 228 ++++++++++++++++++++++
 tb/tb_acc_data_mover.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_mover_pkg.sv
// Shared types and sizing for the accelerator data mover.
package acc_mover_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } mover_state_e;

endpackage

// File: rtl/mover_fifo.sv
// Small read-data FIFO between the memory read port and the accelerator input stream.
module mover_fifo
  import acc_mover_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [DATA_W-1:0]     head_data,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);

  localparam logic [FIFO_CNT_W-1:0] CNT_ONE  = FIFO_CNT_W'(1);
  localparam logic [FIFO_CNT_W-1:0] CNT_FULL = FIFO_CNT_W'(FIFO_DEPTH);
  localparam logic [FIFO_PTR_W-1:0] PTR_ONE  = FIFO_PTR_W'(1);

  logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]     mem_d [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CNT_FULL);
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed through a non-empty count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/acc_data_mover.sv
// Moves a block of words memory -> accelerator -> memory for one accelerator job.
// Optional busy-cycle counter enabled by defining MOVER_PERF_CNT_EN.
module acc_data_mover
  import acc_mover_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              acc_in_valid,
  output logic [31:0]       acc_in_data,
  input  logic              acc_in_ready,
  input  logic              acc_out_valid,
  input  logic [31:0]       acc_out_data,
  output logic              acc_out_ready,
  output logic              read_done,
  output logic              write_done,
  output logic [15:0]       cycle_count
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam int unsigned      OCC_W   = FIFO_CNT_W + 1;

  mover_state_e      state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d, popped_q, popped_d, written_q, written_d;
  logic              outstanding_q, outstanding_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              read_done_q, read_done_d, write_done_q, write_done_d;

  logic                  fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [DATA_W-1:0]     fifo_head;
  logic                  busy, abort, rd_req, wr_req, in_fire, out_fire;

  always_comb begin
    busy       = (state_q == ST_READ) || (state_q == ST_WRITE);
    abort      = busy && !enable;
    // One read in flight at a time, and never more words claimed than FIFO slots.
    rd_req     = (state_q == ST_READ) && (issued_q < len_q) && !outstanding_q &&
                 ((OCC_W'(fifo_count) + OCC_W'(outstanding_q)) < OCC_W'(FIFO_DEPTH));
    wr_req     = (state_q == ST_WRITE) && hold_full_q;
    in_fire    = acc_in_valid && acc_in_ready;
    out_fire   = acc_out_valid && acc_out_ready;
    fifo_push  = (state_q == ST_READ) && outstanding_q && mem_rvalid && !abort && !fifo_full;
    fifo_pop   = in_fire && !abort;
    fifo_flush = abort;
  end

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    len_d         = len_q;
    issued_d      = issued_q;
    popped_d      = popped_q;
    written_d     = written_q;
    outstanding_d = outstanding_q;
    hold_full_d   = hold_full_q;
    hold_data_d   = hold_data_q;
    read_done_d   = read_done_q;
    write_done_d  = write_done_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          src_d         = src_addr;
          dst_d         = dst_addr;
          len_d         = length;
          issued_d      = '0;
          popped_d      = '0;
          written_d     = '0;
          outstanding_d = 1'b0;
          hold_full_d   = 1'b0;
          if (length == '0) begin
            state_d      = ST_DONE;
            read_done_d  = 1'b1;
            write_done_d = 1'b1;
          end else begin
            state_d      = ST_READ;
            read_done_d  = 1'b0;
            write_done_d = 1'b0;
          end
        end
      end
      ST_READ: begin
        if (abort) begin
          state_d       = ST_IDLE;
          outstanding_d = 1'b0;
          read_done_d   = 1'b0;
          write_done_d  = 1'b0;
        end else begin
          if (outstanding_q && mem_rvalid) outstanding_d = 1'b0;
          if (rd_req && mem_gnt) begin
            issued_d      = issued_q + LEN_ONE;
            outstanding_d = 1'b1;
          end
          if (in_fire) begin
            popped_d = popped_q + LEN_ONE;
            if (popped_q + LEN_ONE == len_q) begin
              state_d     = ST_WRITE;
              read_done_d = 1'b1;
            end
          end
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_d      = ST_IDLE;
          hold_full_d  = 1'b0;
          read_done_d  = 1'b0;
          write_done_d = 1'b0;
        end else begin
          if (out_fire) begin
            hold_full_d = 1'b1;
            hold_data_d = acc_out_data;
          end
          if (wr_req && mem_gnt) begin
            hold_full_d = 1'b0;
            written_d   = written_q + LEN_ONE;
            if (written_q + LEN_ONE == len_q) begin
              state_d      = ST_DONE;
              write_done_d = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        if (!enable) begin
          state_d      = ST_IDLE;
          read_done_d  = 1'b0;
          write_done_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      popped_q      <= '0;
      written_q     <= '0;
      outstanding_q <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_data_q   <= '0;
      read_done_q   <= 1'b0;
      write_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      popped_q      <= popped_d;
      written_q     <= written_d;
      outstanding_q <= outstanding_d;
      hold_full_q   <= hold_full_d;
      hold_data_q   <= hold_data_d;
      read_done_q   <= read_done_d;
      write_done_q  <= write_done_d;
    end
  end

  mover_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (mem_rdata),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    acc_in_valid  = (state_q == ST_READ) && !fifo_empty;
    acc_in_data   = acc_in_valid ? fifo_head : '0;
    acc_out_ready = (state_q == ST_WRITE) && !hold_full_q;
    mem_req       = rd_req || wr_req;
    mem_we        = wr_req;
    mem_wdata     = wr_req ? hold_data_q : '0;
    if (rd_req)      mem_addr = src_q + ADDR_W'(issued_q);
    else if (wr_req) mem_addr = dst_q + ADDR_W'(written_q);
    else             mem_addr = '0;
    read_done     = read_done_q;
    write_done    = write_done_q;
  end

`ifdef MOVER_PERF_CNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == ST_IDLE && enable) cyc_d = '0;
    else if (busy && cyc_q != '1)     cyc_d = cyc_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_acc_data_mover.sv
// Scoreboard bench for acc_data_mover: memory and accelerator models, expected traffic queued at job start.
module tb_acc_data_mover;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset, enable;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [LEN_W-1:0]  length;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt, mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              acc_in_valid, acc_in_ready;
  logic [31:0]       acc_in_data;
  logic              acc_out_valid, acc_out_ready;
  logic [31:0]       acc_out_data;
  logic              read_done, write_done;
  logic [15:0]       cycle_count;

  always #5 clk = ~clk;

  acc_data_mover #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .length        (length),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .acc_in_valid  (acc_in_valid),
    .acc_in_data   (acc_in_data),
    .acc_in_ready  (acc_in_ready),
    .acc_out_valid (acc_out_valid),
    .acc_out_data  (acc_out_data),
    .acc_out_ready (acc_out_ready),
    .read_done     (read_done),
    .write_done    (write_done),
    .cycle_count   (cycle_count)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  logic [31:0] mem [0:65535];
  logic [15:0] exp_rd[$];
  logic [31:0] exp_in[$];
  logic [15:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [31:0] acc_q[$];

  logic        rd_pend = 1'b0;
  logic [31:0] rd_pend_data = '0;
  logic        gnt_rand, gnt_off, in_en, in_stall, out_en;
  logic        saw_req;
  int unsigned rd_grants, pops, max_occ;

  function automatic logic [31:0] acc_fn(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h0F0F_F0F0;
  endfunction

  // Memory + accelerator model: drive inputs at negedge, record handshakes just before the next posedge.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    acc_in_ready = 1'b0; acc_out_valid = 1'b0; acc_out_data = '0;
    forever begin
      @(negedge clk);
      mem_rvalid    = rd_pend;
      mem_rdata     = rd_pend ? rd_pend_data : '0;
      rd_pend       = 1'b0;
      mem_gnt       = !gnt_off && (gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
      acc_in_ready  = in_en && !in_stall;
      acc_out_valid = out_en && (acc_q.size() != 0);
      acc_out_data  = acc_out_valid ? acc_q[0] : '0;
      #1;
      if (mem_req) saw_req = 1'b1;
      if (reset && mem_req && mem_gnt) begin
        if (mem_we) begin
          if (exp_wa.size() == 0) check("wr_extra", 32'(exp_wa.size()), 32'd1);
          else begin
            check("wr_addr", 32'(mem_addr), 32'(exp_wa.pop_front()));
            check("wr_data", mem_wdata, exp_wd.pop_front());
          end
          mem[mem_addr] = mem_wdata;
        end else begin
          if (exp_rd.size() == 0) check("rd_extra", 32'(exp_rd.size()), 32'd1);
          else check("rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
          rd_pend      = 1'b1;
          rd_pend_data = mem[mem_addr];
          rd_grants++;
        end
      end
      if (reset && acc_in_valid && acc_out_ready)
        check("in_valid_in_write", 32'(acc_in_valid), 32'd0);
      if (reset && acc_in_valid && acc_in_ready) begin
        if (exp_in.size() == 0) check("in_extra", 32'(exp_in.size()), 32'd1);
        else check("in_data", acc_in_data, exp_in.pop_front());
        acc_q.push_back(acc_fn(acc_in_data));
        pops++;
      end
      if (reset && acc_out_valid && acc_out_ready) void'(acc_q.pop_front());
      if (rd_grants - pops > max_occ) max_occ = rd_grants - pops;
    end
  end

  task automatic clear_model();
    exp_rd.delete(); exp_in.delete(); exp_wa.delete(); exp_wd.delete(); acc_q.delete();
    rd_grants = 0; pops = 0; max_occ = 0; saw_req = 1'b0;
  endtask

  task automatic start_job(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
    logic [15:0] a;
    clear_model();
    for (int unsigned i = 0; i < 32'(n); i++) begin
      a = s + 16'(i);
      exp_rd.push_back(a);
      exp_in.push_back(mem[a]);
      exp_wa.push_back(d + 16'(i));
      exp_wd.push_back(acc_fn(mem[a]));
    end
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; length = n; enable = 1'b1;
  endtask

  task automatic wait_read(input logic [7:0] n, output int unsigned waited);
    waited = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #2;
      waited++;
      if (read_done) break;
    end
    check("read_done", 32'(read_done), 32'd1);
    check("pops_at_read_done", pops, 32'(n));
    check("rd_left", 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic wait_write(output int unsigned waited);
    waited = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #2;
      waited++;
      if (write_done) break;
    end
    check("write_done", 32'(write_done), 32'd1);
    check("read_done_held", 32'(read_done), 32'd1);
    check("wr_left", 32'(exp_wa.size()), 32'd0);
    check("done_mem_req", 32'(mem_req), 32'd0);
    check("done_out_ready", 32'(acc_out_ready), 32'd0);
  endtask

  task automatic end_job();
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    check("flags_clear_rd", 32'(read_done), 32'd0);
    check("flags_clear_wr", 32'(write_done), 32'd0);
  endtask

  task automatic run_job(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
    int unsigned r, w;
    start_job(s, d, n);
    wait_read(n, r);
    wait_write(w);
`ifdef MOVER_PERF_CNT_EN
    check("cycle_count", 32'(cycle_count), r + w - 2);
`else
    check("cycle_count", 32'(cycle_count), 32'd0);
`endif
    end_job();
  endtask

  initial begin
    int unsigned r, w;
    reset = 1'b0; enable = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    gnt_rand = 1'b0; gnt_off = 1'b0; in_en = 1'b1; in_stall = 1'b0; out_en = 1'b1;
    clear_model();
    for (int i = 0; i < 65536; i++) mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h1234_5678;

    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_in_valid", 32'(acc_in_valid), 32'd0);
    check("rst_out_ready", 32'(acc_out_ready), 32'd0);
    check("rst_flags", {30'd0, read_done, write_done}, 32'd0);
    check("rst_cycles", 32'(cycle_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_job(16'h0010, 16'h0100, 8'd4);

    // Backpressure: accelerator stalls for five cycles mid-read, grants random.
    gnt_rand = 1'b1;
    start_job(16'h0200, 16'hFFFF, 8'd6);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #2;
      if (pops >= 1) break;
    end
    check("bp_first_pop", 32'(pops >= 1), 32'd1);
    in_stall = 1'b1;
    repeat (5) @(negedge clk);
    #2 in_stall = 1'b0;
    wait_read(8'd6, r);
    wait_write(w);
    check("bp_max_occ", max_occ, 32'd2);
    end_job();
    gnt_rand = 1'b0;

    // Empty job.
    start_job(16'h0010, 16'h0100, 8'd0);
    @(negedge clk); #2;
    check("zl_pre_rd", 32'(read_done), 32'd0);
    @(negedge clk); #2;
    check("zl_rd", 32'(read_done), 32'd1);
    check("zl_wr", 32'(write_done), 32'd1);
    repeat (2) @(negedge clk);
    #2;
    check("zl_no_req", 32'(saw_req), 32'd0);
    check("zl_cycles", 32'(cycle_count), 32'd0);
    end_job();

    run_job(16'hFFFE, 16'h0900, 8'd4);

    // Abort in READ with a read return arriving alongside the enable drop.
    in_en = 1'b0;
    start_job(16'h0300, 16'h0400, 8'd4);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #2;
      if (rd_grants == 2) break;
    end
    check("ab_two_reads", rd_grants, 32'd2);
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    check("ab_in_valid", 32'(acc_in_valid), 32'd0);
    check("ab_mem_req", 32'(mem_req), 32'd0);
    check("ab_flags", {30'd0, read_done, write_done}, 32'd0);
    clear_model();
    in_en = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("ab_in_valid_later", 32'(acc_in_valid), 32'd0);
    check("ab_no_pops", pops, 32'd0);
    run_job(16'h0500, 16'h0600, 8'd2);

    // Reset while WRITE holds a word waiting for grant.
    start_job(16'h0700, 16'h0800, 8'd4);
    wait_read(8'd4, r);
    gnt_off = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("hold_req", 32'(mem_req), 32'd1);
    check("hold_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    check("wrst_mem_req", 32'(mem_req), 32'd0);
    check("wrst_flags", {30'd0, read_done, write_done}, 32'd0);
    check("wrst_cycles", 32'(cycle_count), 32'd0);
    check("wrst_out_ready", 32'(acc_out_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; enable = 1'b0; gnt_off = 1'b0;
    clear_model();
    run_job(16'h0A00, 16'h0B00, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
